// File: rtl/kf8259_acknowledge_control.sv
// kf8259_acknowledge_control
// Sequences the 8086-mode two-pulse INTA# acknowledge, drives the vector byte,
// issues the in-service set strobe, and turns OCW2 writes (plus AEOI) into
// end-of-interrupt clear pulses and priority rotation updates.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   interrupt_acknowledge_n      INTA#, already synchronous to clock
//   highest_request              one-hot winning request (0 = none)
//   highest_level_in_service     one-hot highest in-service level
//   write_ocw2, internal_data_bus  OCW2 strobe and byte {R,SL,EOI,x,x,L[2:0]}
//   interrupt_vector_base        ICW2 T7..T3
//   auto_eoi                     ICW4 AEOI
//   interrupt                    one-hot level being acknowledged
//   start_in_service             one-cycle in-service set strobe
//   end_of_interrupt             one-hot in-service clear pulse
//   priority_rotate              current lowest-priority level
//   out_data_bus, out_data_bus_enable  vector byte and its drive enable
module kf8259_acknowledge_control (
  input  logic       clock,
  input  logic       reset,
  input  logic       interrupt_acknowledge_n,
  input  logic [7:0] highest_request,
  input  logic [7:0] highest_level_in_service,
  input  logic       write_ocw2,
  input  logic [7:0] internal_data_bus,
  input  logic [4:0] interrupt_vector_base,
  input  logic       auto_eoi,
  output logic [7:0] interrupt,
  output logic       start_in_service,
  output logic [7:0] end_of_interrupt,
  output logic [2:0] priority_rotate,
  output logic [7:0] out_data_bus,
  output logic       out_data_bus_enable
);

  typedef enum logic [1:0] {IDLE, ACK1, WAIT2, ACK2} state_t;

  state_t     state, state_d;
  logic       inta_q;
  logic       spurious, spurious_d;
  logic       auto_rotate_mode, auto_rotate_mode_d;
  logic [7:0] interrupt_d;
  logic       start_in_service_d;
  logic [7:0] end_of_interrupt_d;
  logic [2:0] priority_rotate_d;
  logic [7:0] out_data_bus_d;
  logic       out_data_bus_enable_d;

  logic       fall, rise;
  logic [2:0] ack_level;
  logic       ocw_r, ocw_sl, ocw_eoi;
  logic [2:0] ocw_level;
  logic [7:0] ocw_specific_mask;

  function automatic logic [2:0] encode(input logic [7:0] onehot);
    encode = '0;
    for (int unsigned i = 0; i < 8; i++)
      if (onehot[i]) encode = i[2:0];
  endfunction

  assign fall = inta_q & ~interrupt_acknowledge_n;
  assign rise = ~inta_q & interrupt_acknowledge_n;

  // A spurious acknowledge latches no request but still reports level 7.
  assign ack_level = spurious ? 3'd7 : encode(interrupt);

  assign ocw_r             = internal_data_bus[7];
  assign ocw_sl            = internal_data_bus[6];
  assign ocw_eoi           = internal_data_bus[5];
  assign ocw_level         = internal_data_bus[2:0];
  assign ocw_specific_mask = 8'b0000_0001 << ocw_level;

  always_comb begin
    state_d               = state;
    interrupt_d           = interrupt;
    spurious_d            = spurious;
    start_in_service_d    = 1'b0;
    end_of_interrupt_d    = '0;
    priority_rotate_d     = priority_rotate;
    out_data_bus_d        = out_data_bus;
    out_data_bus_enable_d = out_data_bus_enable;
    auto_rotate_mode_d    = auto_rotate_mode;

    unique case (state)
      IDLE: if (fall) begin
        state_d            = ACK1;
        interrupt_d        = highest_request;
        spurious_d         = ~|highest_request;
        start_in_service_d = |highest_request;
      end
      ACK1: if (rise) state_d = WAIT2;
      WAIT2: if (fall) begin
        state_d               = ACK2;
        out_data_bus_d        = {interrupt_vector_base, ack_level};
        out_data_bus_enable_d = 1'b1;
      end
      ACK2: if (rise) begin
        state_d               = IDLE;
        interrupt_d           = '0;
        out_data_bus_d        = '0;
        out_data_bus_enable_d = 1'b0;
        if (auto_eoi && !spurious) begin
          end_of_interrupt_d = interrupt;
          if (auto_rotate_mode) priority_rotate_d = ack_level;
        end
      end
      default: state_d = IDLE;
    endcase

    // OCW2 is evaluated after AEOI so its rotate value takes precedence;
    // clear masks from both sources are merged.
    if (write_ocw2) begin
      unique case ({ocw_r, ocw_sl, ocw_eoi})
        3'b001: end_of_interrupt_d = end_of_interrupt_d | highest_level_in_service;
        3'b011: end_of_interrupt_d = end_of_interrupt_d | ocw_specific_mask;
        3'b101: begin
          end_of_interrupt_d = end_of_interrupt_d | highest_level_in_service;
          if (|highest_level_in_service)
            priority_rotate_d = encode(highest_level_in_service);
        end
        3'b111: begin
          end_of_interrupt_d = end_of_interrupt_d | ocw_specific_mask;
          priority_rotate_d  = ocw_level;
        end
        3'b110: priority_rotate_d  = ocw_level;
        3'b100: auto_rotate_mode_d = 1'b1;
        3'b000: auto_rotate_mode_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      inta_q              <= 1'b1;
      spurious            <= 1'b0;
      auto_rotate_mode    <= 1'b0;
      interrupt           <= '0;
      start_in_service    <= 1'b0;
      end_of_interrupt    <= '0;
      priority_rotate     <= 3'b111;
      out_data_bus        <= '0;
      out_data_bus_enable <= 1'b0;
    end else begin
      state               <= state_d;
      inta_q              <= interrupt_acknowledge_n;
      spurious            <= spurious_d;
      auto_rotate_mode    <= auto_rotate_mode_d;
      interrupt           <= interrupt_d;
      start_in_service    <= start_in_service_d;
      end_of_interrupt    <= end_of_interrupt_d;
      priority_rotate     <= priority_rotate_d;
      out_data_bus        <= out_data_bus_d;
      out_data_bus_enable <= out_data_bus_enable_d;
    end
  end

endmodule

// File: tb/tb_kf8259_acknowledge_control.sv
// Self-checking bench for kf8259_acknowledge_control: directed cases followed
// by randomized acknowledge cycles and OCW2 writes, compared against a
// transaction-level model of the acknowledge timing and OCW2 semantics.
module tb_kf8259_acknowledge_control;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       inta_n = 1'b1;
  logic [7:0] hr = '0;
  logic [7:0] hlis = '0;
  logic       wr = 1'b0;
  logic [7:0] idb = '0;
  logic [4:0] base = '0;
  logic       aeoi = 1'b0;

  logic [7:0] interrupt;
  logic       start_in_service;
  logic [7:0] end_of_interrupt;
  logic [2:0] priority_rotate;
  logic [7:0] out_data_bus;
  logic       out_data_bus_enable;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [2:0] m_rot = 3'b111;
  logic       m_arm = 1'b0;

  kf8259_acknowledge_control dut (
    .clock                    (clock),
    .reset                    (reset),
    .interrupt_acknowledge_n  (inta_n),
    .highest_request          (hr),
    .highest_level_in_service (hlis),
    .write_ocw2               (wr),
    .internal_data_bus        (idb),
    .interrupt_vector_base    (base),
    .auto_eoi                 (aeoi),
    .interrupt                (interrupt),
    .start_in_service         (start_in_service),
    .end_of_interrupt         (end_of_interrupt),
    .priority_rotate          (priority_rotate),
    .out_data_bus             (out_data_bus),
    .out_data_bus_enable      (out_data_bus_enable)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] idx(input logic [7:0] v);
    idx = 3'd0;
    for (int k = 0; k < 8; k++)
      if (v == (8'h01 << k)) idx = 3'(k);
  endfunction

  function automatic logic [7:0] rand_onehot();
    return 8'h01 << $urandom_range(0, 7);
  endfunction

  // Effect of one OCW2 byte: clear mask plus an optional new lowest priority.
  task automatic ocw_effect(input logic [7:0] b, input logic [7:0] lis,
                            output logic [7:0] eoi, output bit rv, output logic [2:0] rl);
    logic [2:0] l;
    l = b[2:0];
    eoi = '0; rv = 0; rl = '0;
    if (b[5]) begin
      eoi = b[6] ? (8'h01 << l) : lis;
      if (b[7]) begin
        if (b[6]) begin rv = 1; rl = l; end
        else if (lis != 0) begin rv = 1; rl = idx(lis); end
      end
    end else if (b[7] && b[6]) begin
      rv = 1; rl = l;
    end
  endtask

  task automatic arm_effect(input logic [7:0] b);
    if (b[7:5] == 3'b100) m_arm = 1'b1;
    if (b[7:5] == 3'b000) m_arm = 1'b0;
  endtask

  // Entered and left just after a falling clock edge.
  task automatic do_ocw(input logic [7:0] b, input logic [7:0] lis);
    logic [7:0] e; bit rv; logic [2:0] rl;
    wr = 1'b1; idb = b; hlis = lis;
    ocw_effect(b, lis, e, rv, rl);
    if (rv) m_rot = rl;
    arm_effect(b);
    @(negedge clock);
    wr = 1'b0;
    chk("ocw_eoi", end_of_interrupt, e);
    chk("ocw_rot", 8'(priority_rotate), 8'(m_rot));
    @(negedge clock);
    chk("ocw_eoi_clear", end_of_interrupt, 8'h00);
  endtask

  // Full two-pulse acknowledge; optionally writes OCW2 in the cycle of the final rise.
  task automatic ack(input logic [7:0] hr_v, input logic [4:0] base_v, input logic aeoi_v,
                     input int w1, input int g, input int w2,
                     input bit ocw_en, input logic [7:0] ocw_b, input logic [7:0] lis);
    logic [2:0] lvl; logic [7:0] ae_mask, oe_mask, vec; bit rv; logic [2:0] rl;
    lvl = (hr_v == 0) ? 3'd7 : idx(hr_v);
    vec = {base_v, lvl};
    base = base_v; aeoi = aeoi_v; hr = hr_v; inta_n = 1'b0;
    for (int i = 1; i <= w1; i++) begin
      @(negedge clock);
      hr = rand_onehot();
      chk("ack1_interrupt", interrupt, hr_v);
      chk("ack1_sis", 8'(start_in_service), 8'((i == 1) && (hr_v != 0)));
      chk("ack1_oe", 8'(out_data_bus_enable), 8'h00);
      if (i == w1) inta_n = 1'b1;
    end
    for (int i = 1; i <= g; i++) begin
      @(negedge clock);
      chk("gap_interrupt", interrupt, hr_v);
      chk("gap_sis", 8'(start_in_service), 8'h00);
      chk("gap_oe", 8'(out_data_bus_enable), 8'h00);
      if (i == g) inta_n = 1'b0;
    end
    for (int i = 1; i <= w2; i++) begin
      @(negedge clock);
      chk("ack2_interrupt", interrupt, hr_v);
      chk("ack2_oe", 8'(out_data_bus_enable), 8'h01);
      chk("ack2_vector", out_data_bus, vec);
      chk("ack2_eoi", end_of_interrupt, 8'h00);
      if (i == w2) begin
        inta_n = 1'b1;
        if (ocw_en) begin wr = 1'b1; idb = ocw_b; hlis = lis; end
      end
    end
    ae_mask = (aeoi_v && hr_v != 0) ? hr_v : 8'h00;
    if (aeoi_v && hr_v != 0 && m_arm) m_rot = lvl;
    oe_mask = '0;
    if (ocw_en) begin
      ocw_effect(ocw_b, lis, oe_mask, rv, rl);
      if (rv) m_rot = rl;
      arm_effect(ocw_b);
    end
    @(negedge clock);
    wr = 1'b0;
    chk("end_eoi", end_of_interrupt, ae_mask | oe_mask);
    chk("end_rot", 8'(priority_rotate), 8'(m_rot));
    chk("end_oe", 8'(out_data_bus_enable), 8'h00);
    chk("end_interrupt", interrupt, 8'h00);
    @(negedge clock);
    chk("end_eoi_clear", end_of_interrupt, 8'h00);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_interrupt"}, interrupt, 8'h00);
    chk({tag, "_sis"}, 8'(start_in_service), 8'h00);
    chk({tag, "_eoi"}, end_of_interrupt, 8'h00);
    chk({tag, "_rot"}, 8'(priority_rotate), 8'h07);
    chk({tag, "_odb"}, out_data_bus, 8'h00);
    chk({tag, "_oe"}, 8'(out_data_bus_enable), 8'h00);
  endtask

  initial begin
    // Reset then idle.
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk_reset_values("reset");

    // Plain acknowledge of level 3, vector base 4 -> 8'h23.
    ack(8'h08, 5'h04, 1'b0, 3, 2, 3, 0, 8'h00, 8'h00);

    // Auto-rotate on, then AEOI acknowledge of level 3.
    do_ocw(8'h80, 8'h00);
    ack(8'h08, 5'h04, 1'b1, 3, 2, 3, 0, 8'h00, 8'h00);

    // Spurious acknowledge with AEOI enabled.
    ack(8'h00, 5'h11, 1'b1, 2, 1, 2, 0, 8'h00, 8'h00);

    // OCW2 decode.
    do_ocw(8'h20, 8'h20);
    do_ocw(8'h63, 8'h20);
    do_ocw(8'hA0, 8'h20);
    do_ocw(8'hC1, 8'h20);
    do_ocw(8'h20, 8'h00);
    do_ocw(8'hA0, 8'h00);

    // OCW2 and AEOI in the same cycle: masks merge, OCW2 rotate wins.
    ack(8'h10, 5'h1F, 1'b1, 1, 1, 1, 1, 8'hE2, 8'h00);

    // Reset while waiting for the second pulse.
    do_ocw(8'h80, 8'h00);
    aeoi = 1'b0; hr = 8'h40; inta_n = 1'b0;
    repeat (2) @(negedge clock);
    inta_n = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    chk_reset_values("midreset");
    m_rot = 3'b111; m_arm = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    ack(8'h01, 5'h0A, 1'b1, 2, 2, 2, 0, 8'h00, 8'h00);

    // Randomized mix of acknowledges and OCW2 writes.
    for (int n = 0; n < 30; n++) begin
      logic [7:0] b, lis, rq;
      b   = 8'($urandom_range(0, 255)) & 8'hE7;
      lis = ($urandom_range(0, 4) == 0) ? 8'h00 : rand_onehot();
      rq  = ($urandom_range(0, 4) == 0) ? 8'h00 : rand_onehot();
      if ($urandom_range(0, 1) == 1)
        do_ocw(b, lis);
      else
        ack(rq, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            $urandom_range(1, 4), $urandom_range(1, 3), $urandom_range(1, 4),
            1'($urandom_range(0, 3) == 0), b, lis);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
